paddle_position_ctrl: RTL and testbench

- Downstream consumer of the PS/2 keyboard stage: takes its start, moveUp and moveDown level outputs and turns them into the player paddle's vertical position for the game/VGA drawing logic.
- Owns the game run state (idle / playing / paused):
  - Press-to-step movement with hold auto-repeat.
  - Bounds clamping.
  - A one-cycle update strobe so the renderer redraws only on change.

---
 rtl/paddle_position_ctrl_pkg.sv | 43 ++++
 rtl/paddle_position_ctrl_hold_repeat_pulser.sv | 81 ++++++++
 rtl/paddle_position_ctrl.sv | 141 ++++++++++++++
 tb/tb_paddle_position_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/paddle_position_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// paddle_position_ctrl_pkg
//
// Shared definitions for the player paddle controller:
//   - default game geometry (paddle row range, start row, step size)
//   - default auto-repeat interval for a held key
//   - the game run-state encoding used by the top-level FSM
//   - a helper that sizes the auto-repeat counter
// ---------------------------------------------------------------------------
package paddle_position_ctrl_pkg;

  // Game geometry defaults: rows are counted from the top of the play field.
  localparam int Y_WIDTH_DEF       = 7;
  localparam int Y_MIN_DEF         = 0;
  localparam int Y_MAX_DEF         = 100;
  localparam int Y_INIT_DEF        = 50;
  localparam int STEP_DEF          = 2;

  // 50 ms between auto-repeat steps at a 50 MHz clock.
  localparam int REPEAT_CYCLES_DEF = 2500000;

  // Game run state. The encoding is fixed so the renderer and any debug
  // tooling can decode it directly.
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    PLAYING = 2'b01,
    PAUSED  = 2'b10
  } game_state_t;

  // Width of the auto-repeat counter. The counter only has to reach
  // cycles-1, so $clog2(cycles) bits suffice; a single-cycle repeat still
  // needs one bit so the counter vector is never zero-width.
  function automatic int repeat_cnt_width(input int cycles);
    int width;
    if (cycles > 1) begin
      width = $clog2(cycles);
    end else begin
      width = 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/paddle_position_ctrl_hold_repeat_pulser.sv
// ---------------------------------------------------------------------------
// hold_repeat_pulser
//
// Turns one key level into step requests: one request on the rising edge,
// then one more every REPEAT_CYCLES clocks while the key stays held.
//
// Ports:
//   CLOCK_50   in  system clock
//   reset      in  asynchronous, active-high; clears history and counter
//   enable     in  high while movement is allowed (game PLAYING)
//   level_in   in  key level, synchronous to CLOCK_50
//   step_pulse out combinational step request, valid in the cycle it is
//                  issued so the consumer can act on the same clock edge
// ---------------------------------------------------------------------------
module hold_repeat_pulser
  import paddle_position_ctrl_pkg::*;
#(
  parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic enable,
  input  logic level_in,
  output logic step_pulse
);

  localparam int                CNT_W    = repeat_cnt_width(REPEAT_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  logic             level_prev;
  logic             rise;
  logic             armed;
  logic             armed_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  // The history register tracks the key even while disabled, so a key that
  // is already down when movement becomes allowed shows no rising edge.
  assign rise = level_in & ~level_prev;

  // Step/repeat decision.
  // 'armed' records that the current hold began with a rising edge seen
  // while enabled. Without it, a key held through a pause (or held when the
  // game starts) would start auto-repeating after REPEAT_CYCLES even though
  // it was never freshly pressed. Disabling or releasing disarms it and
  // returns the counter to zero.
  always_comb begin
    step_pulse = 1'b0;
    armed_next = 1'b0;
    cnt_next   = '0;
    if (enable) begin
      if (rise) begin
        step_pulse = 1'b1;
        armed_next = 1'b1;
        cnt_next   = '0;
      end else if (level_in && armed) begin
        armed_next = 1'b1;
        if (cnt == CNT_LAST) begin
          step_pulse = 1'b1;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
    end
  end

  // History, arm flag and repeat counter.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      level_prev <= 1'b0;
      armed      <= 1'b0;
      cnt        <= '0;
    end else begin
      level_prev <= level_in;
      armed      <= armed_next;
      cnt        <= cnt_next;
    end
  end

endmodule

// File: rtl/paddle_position_ctrl.sv
// ---------------------------------------------------------------------------
// paddle_position_ctrl
//
// Converts the keyboard stage's start / moveUp / moveDown levels into the
// player paddle row, and owns the game run state (idle / playing / paused).
//
// Ports:
//   CLOCK_50   in  system clock, 50 MHz
//   reset      in  asynchronous, active-high; clears all state
//   start      in  level, high while P is the last key received
//   moveUp     in  level, high while the up key is held
//   moveDown   in  level, high while the down key is held
//   y_pos      out current paddle row, Y_MIN..Y_MAX
//   pos_update out one-cycle strobe, high in the first cycle y_pos shows a
//                  new value (renderer redraws only then)
//   playing    out high in PLAYING
//   paused     out high in PAUSED
// ---------------------------------------------------------------------------
module paddle_position_ctrl
  import paddle_position_ctrl_pkg::*;
#(
  parameter int Y_WIDTH       = Y_WIDTH_DEF,
  parameter int Y_MIN         = Y_MIN_DEF,
  parameter int Y_MAX         = Y_MAX_DEF,
  parameter int Y_INIT        = Y_INIT_DEF,
  parameter int STEP          = STEP_DEF,
  parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               start,
  input  logic               moveUp,
  input  logic               moveDown,
  output logic [Y_WIDTH-1:0] y_pos,
  output logic               pos_update,
  output logic               playing,
  output logic               paused
);

  // One extra bit of headroom so y+STEP and the bound comparisons never wrap.
  localparam int                 XW       = Y_WIDTH + 1;
  localparam logic [XW-1:0]      STEP_X   = XW'(STEP);
  localparam logic [XW-1:0]      MIN_X    = XW'(Y_MIN);
  localparam logic [XW-1:0]      MAX_X    = XW'(Y_MAX);
  localparam logic [Y_WIDTH-1:0] INIT_Y   = Y_WIDTH'(Y_INIT);

  game_state_t        state;
  game_state_t        state_next;
  logic               start_prev;
  logic               start_rise;
  logic               move_enable;
  logic               up_req;
  logic               down_req;
  logic [XW-1:0]      y_ext;
  logic [XW-1:0]      y_up;
  logic [XW-1:0]      y_down;
  logic [XW-1:0]      y_sum;
  logic [Y_WIDTH-1:0] y_next;
  logic               update_next;

  assign start_rise  = start & ~start_prev;
  assign move_enable = (state == PLAYING);
  assign playing     = (state == PLAYING);
  assign paused      = (state == PAUSED);

  // One pulser per direction; both see the same enable so their counters
  // are held at zero outside PLAYING.
  hold_repeat_pulser #(
    .REPEAT_CYCLES (REPEAT_CYCLES)
  ) u_up_pulser (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .enable     (move_enable),
    .level_in   (moveUp),
    .step_pulse (up_req)
  );

  hold_repeat_pulser #(
    .REPEAT_CYCLES (REPEAT_CYCLES)
  ) u_down_pulser (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .enable     (move_enable),
    .level_in   (moveDown),
    .step_pulse (down_req)
  );

  // Clamped candidate rows. The up case compares y against Y_MIN+STEP
  // instead of forming y-STEP first, which is the same test without ever
  // producing a borrow.
  always_comb begin
    y_ext  = {1'b0, y_pos};
    y_sum  = y_ext + STEP_X;
    y_up   = (y_ext < (MIN_X + STEP_X)) ? MIN_X : (y_ext - STEP_X);
    y_down = (y_sum > MAX_X) ? MAX_X : y_sum;
  end

  // Next state, next row and update strobe.
  // A start edge always wins over a move in the same cycle. Simultaneous up
  // and down requests cancel. The strobe is derived from an actual change
  // of value, which also covers a clamped step at the bound and the
  // IDLE->PLAYING reload when the paddle already sits at Y_INIT.
  always_comb begin
    state_next = state;
    y_next     = y_pos;
    if (start_rise) begin
      case (state)
        IDLE: begin
          state_next = PLAYING;
          y_next     = INIT_Y;
        end
        PLAYING: state_next = PAUSED;
        PAUSED:  state_next = PLAYING;
        default: state_next = IDLE;
      endcase
    end else if (state == PLAYING) begin
      if (up_req && !down_req) begin
        y_next = y_up[Y_WIDTH-1:0];
      end else if (down_req && !up_req) begin
        y_next = y_down[Y_WIDTH-1:0];
      end
    end
    update_next = (y_next != y_pos);
  end

  // State, paddle row, strobe and start-edge history.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      y_pos      <= INIT_Y;
      pos_update <= 1'b0;
      start_prev <= 1'b0;
    end else begin
      state      <= state_next;
      y_pos      <= y_next;
      pos_update <= update_next;
      start_prev <= start;
    end
  end

endmodule

// File: tb/tb_paddle_position_ctrl.sv
// ---------------------------------------------------------------------------
// tb_paddle_position_ctrl
//
// Directed bench for paddle_position_ctrl with a short auto-repeat interval
// (8 clocks). Expected rows are worked out by hand from the default
// geometry: range 0..100, start row 50, step 2.
// ---------------------------------------------------------------------------
module tb_paddle_position_ctrl;

  logic       CLOCK_50;
  logic       reset;
  logic       start;
  logic       moveUp;
  logic       moveDown;
  logic [6:0] y_pos;
  logic       pos_update;
  logic       playing;
  logic       paused;

  int assertCount;
  int failCount;
  int strobes;
  logic tapStrobe;

  paddle_position_ctrl #(
    .REPEAT_CYCLES (8)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .start      (start),
    .moveUp     (moveUp),
    .moveDown   (moveDown),
    .y_pos      (y_pos),
    .pos_update (pos_update),
    .playing    (playing),
    .paused     (paused)
  );

  // 50 MHz-style free-running clock (period 10 time units).
  initial begin
    CLOCK_50 = 1'b0;
    forever #5 CLOCK_50 = ~CLOCK_50;
  end

  // Counts one comparison and reports it when observed and expected differ.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drives the three key levels together.
  task automatic applyStimulus(input logic s, input logic up, input logic down);
    start    = s;
    moveUp   = up;
    moveDown = down;
  endtask

  // Advances n clock edges and leaves time 1 unit past the last edge, where
  // outputs are stable and new inputs can be applied.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  // Presses a key for one cycle, then releases it for one cycle; returns the
  // strobe seen right after the press edge.
  task automatic tapKey(input logic up, input logic down, output logic strobe);
    applyStimulus(1'b0, up, down);
    tick(1);
    strobe = pos_update;
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick(1);
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    reset       = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick(2);

    // Reset values
    checkOutput("reset_y", 32'(y_pos), 32'd50);
    checkOutput("reset_upd", 32'(pos_update), 32'd0);
    checkOutput("reset_playing", 32'(playing), 32'd0);
    checkOutput("reset_paused", 32'(paused), 32'd0);
    reset = 1'b0;
    tick(1);
    checkOutput("idle_y", 32'(y_pos), 32'd50);

    // Moves are ignored in IDLE
    applyStimulus(1'b0, 1'b1, 1'b0);
    strobes = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      strobes += int'(pos_update);
    end
    checkOutput("idle_hold_y", 32'(y_pos), 32'd50);
    checkOutput("idle_hold_strobes", 32'(strobes), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick(1);

    // Start the game: reload to 50 is not a change, so no strobe
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick(1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("start_playing", 32'(playing), 32'd1);
    checkOutput("start_paused", 32'(paused), 32'd0);
    checkOutput("start_upd", 32'(pos_update), 32'd0);
    checkOutput("start_y", 32'(y_pos), 32'd50);
    tick(1);

    // Single up press
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick(1);
    checkOutput("up_once_y", 32'(y_pos), 32'd48);
    checkOutput("up_once_upd", 32'(pos_update), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick(1);
    checkOutput("up_once_upd_clear", 32'(pos_update), 32'd0);

    // Held down for 17 edges: steps on edges 0, 8 and 16
    applyStimulus(1'b0, 1'b0, 1'b1);
    strobes = 0;
    for (int i = 0; i < 17; i++) begin
      tick(1);
      strobes += int'(pos_update);
      if (i == 0)  checkOutput("hold_down_e0", 32'(y_pos), 32'd50);
      if (i == 7)  checkOutput("hold_down_e7", 32'(y_pos), 32'd50);
      if (i == 8)  checkOutput("hold_down_e8", 32'(y_pos), 32'd52);
      if (i == 15) checkOutput("hold_down_e15", 32'(y_pos), 32'd52);
      if (i == 16) checkOutput("hold_down_e16", 32'(y_pos), 32'd54);
    end
    checkOutput("hold_down_strobes", 32'(strobes), 32'd3);
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick(1);

    // Top bound: 54 -> 2 in 26 taps, then 0, then clamped with no strobe
    for (int i = 0; i < 26; i++) tapKey(1'b1, 1'b0, tapStrobe);
    checkOutput("walk_up_y", 32'(y_pos), 32'd2);
    tapKey(1'b1, 1'b0, tapStrobe);
    checkOutput("reach_min_y", 32'(y_pos), 32'd0);
    checkOutput("reach_min_upd", 32'(tapStrobe), 32'd1);
    tapKey(1'b1, 1'b0, tapStrobe);
    checkOutput("clamp_min_y", 32'(y_pos), 32'd0);
    checkOutput("clamp_min_upd", 32'(tapStrobe), 32'd0);

    // Bottom bound: 0 -> 98 in 49 taps, then 100, then clamped
    for (int i = 0; i < 49; i++) tapKey(1'b0, 1'b1, tapStrobe);
    checkOutput("walk_down_y", 32'(y_pos), 32'd98);
    tapKey(1'b0, 1'b1, tapStrobe);
    checkOutput("reach_max_y", 32'(y_pos), 32'd100);
    checkOutput("reach_max_upd", 32'(tapStrobe), 32'd1);
    tapKey(1'b0, 1'b1, tapStrobe);
    checkOutput("clamp_max_y", 32'(y_pos), 32'd100);
    checkOutput("clamp_max_upd", 32'(tapStrobe), 32'd0);

    // Both keys rise together: no move; up then repeats 8 edges later
    applyStimulus(1'b0, 1'b1, 1'b1);
    tick(1);
    checkOutput("dual_edge_y", 32'(y_pos), 32'd100);
    checkOutput("dual_edge_upd", 32'(pos_update), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    strobes = 0;
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      if (i < 8) begin
        strobes += int'(pos_update);
      end else begin
        checkOutput("dual_repeat_y", 32'(y_pos), 32'd98);
        checkOutput("dual_repeat_upd", 32'(pos_update), 32'd1);
      end
    end
    checkOutput("dual_gap_strobes", 32'(strobes), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick(1);

    // Pause, hold down while paused
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick(1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("pause_paused", 32'(paused), 32'd1);
    checkOutput("pause_playing", 32'(playing), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    strobes = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      strobes += int'(pos_update);
    end
    checkOutput("paused_hold_y", 32'(y_pos), 32'd98);
    checkOutput("paused_hold_strobes", 32'(strobes), 32'd0);

    // Resume with down still held: no movement until re-pressed
    applyStimulus(1'b1, 1'b0, 1'b1);
    tick(1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("resume_playing", 32'(playing), 32'd1);
    checkOutput("resume_paused", 32'(paused), 32'd0);
    strobes = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      strobes += int'(pos_update);
    end
    checkOutput("resume_hold_y", 32'(y_pos), 32'd98);
    checkOutput("resume_hold_strobes", 32'(strobes), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick(1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    tick(1);
    checkOutput("repress_y", 32'(y_pos), 32'd100);
    checkOutput("repress_upd", 32'(pos_update), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick(1);

    // Walk to 72, then hold up: 70, and reset mid-hold
    for (int i = 0; i < 14; i++) tapKey(1'b1, 1'b0, tapStrobe);
    checkOutput("pre_reset_y", 32'(y_pos), 32'd72);
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick(1);
    checkOutput("hold_70_y", 32'(y_pos), 32'd70);
    tick(3);
    #2;
    reset = 1'b1;
    #2;
    checkOutput("async_reset_y", 32'(y_pos), 32'd50);
    checkOutput("async_reset_playing", 32'(playing), 32'd0);
    checkOutput("async_reset_paused", 32'(paused), 32'd0);
    checkOutput("async_reset_upd", 32'(pos_update), 32'd0);
    tick(2);
    reset = 1'b0;
    strobes = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      strobes += int'(pos_update);
    end
    checkOutput("post_reset_y", 32'(y_pos), 32'd50);
    checkOutput("post_reset_strobes", 32'(strobes), 32'd0);

    // New game with up still held: no step without a fresh press
    applyStimulus(1'b1, 1'b1, 1'b0);
    tick(1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("restart_playing", 32'(playing), 32'd1);
    strobes = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      strobes += int'(pos_update);
    end
    checkOutput("restart_hold_y", 32'(y_pos), 32'd50);
    checkOutput("restart_hold_strobes", 32'(strobes), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
